// File: rtl/glitch_seq.sv
// Clock-glitch sequencer: arm, wait for a trigger edge, then emit repeat+1 glitches
// on clk_out. Optional macro GLITCH_SEQ_TRIG_SYNC_EN adds a 2-flop trigger synchronizer.
module glitch_seq #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int REP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_in,
  input  logic               arm,
  input  logic               abort,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  logic [WIDTH_W-1:0] gap,
  input  logic [REP_W-1:0]   repeats,
  input  logic [7:0]         mode,
  output logic               clk_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_GLITCH,
    S_GAP,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_en, w_en_nxt;
  logic [DELAY_W-1:0] r_delay, w_delay_nxt;
  logic [WIDTH_W-1:0] r_width, w_width_nxt;
  logic [WIDTH_W-1:0] r_gap, w_gap_nxt;
  logic [REP_W-1:0]   r_repeat, w_repeat_nxt;
  logic [7:0]         r_mode, w_mode_nxt;
  logic [DELAY_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [WIDTH_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [WIDTH_W-1:0] r_gcnt, w_gcnt_nxt;
  logic [REP_W-1:0]   r_rcnt, w_rcnt_nxt;
  logic               r_trig_prev;
  logic               w_trig, w_trig_rise;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  logic r_trig_s1, r_trig_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
    end else begin
      r_trig_s1 <= trigger;
      r_trig_s2 <= r_trig_s1;
    end
  end

  assign w_trig = r_trig_s2;
`else
  assign w_trig = trigger;
`endif

  assign w_trig_rise = w_trig & ~r_trig_prev;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_delay_nxt  = r_delay;
    w_width_nxt  = r_width;
    w_gap_nxt    = r_gap;
    w_repeat_nxt = r_repeat;
    w_mode_nxt   = r_mode;
    w_dcnt_nxt   = r_dcnt;
    w_wcnt_nxt   = r_wcnt;
    w_gcnt_nxt   = r_gcnt;
    w_rcnt_nxt   = r_rcnt;

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (arm) begin
            w_delay_nxt  = delay;
            w_width_nxt  = width;
            w_gap_nxt    = gap;
            w_repeat_nxt = repeats;
            w_mode_nxt   = mode;
            w_state_nxt  = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_trig_rise) begin
            w_dcnt_nxt  = r_delay;
            w_rcnt_nxt  = r_repeat;
            w_state_nxt = S_DELAY;
          end
        end
        S_DELAY: begin
          if (r_dcnt == '0) begin
            w_wcnt_nxt  = r_width;
            w_state_nxt = S_GLITCH;
          end else begin
            w_dcnt_nxt = r_dcnt - 1'b1;
          end
        end
        S_GLITCH: begin
          if (r_wcnt != '0) begin
            w_wcnt_nxt = r_wcnt - 1'b1;
          end else if (r_rcnt != '0) begin
            w_rcnt_nxt  = r_rcnt - 1'b1;
            w_gcnt_nxt  = r_gap;
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_GAP: begin
          if (r_gcnt == '0) begin
            w_wcnt_nxt  = r_width;
            w_state_nxt = S_GLITCH;
          end else begin
            w_gcnt_nxt = r_gcnt - 1'b1;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // en is registered from the next state so it is glitch-free and aligned with GLITCH.
  assign w_en_nxt = (w_state_nxt == S_GLITCH);

  always_ff @(posedge clk) begin
    // NOTE: shadow registers and counters are reset too, so a post-reset sequence never
    // starts from stale configuration.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_en        <= 1'b0;
      r_delay     <= '0;
      r_width     <= '0;
      r_gap       <= '0;
      r_repeat    <= '0;
      r_mode      <= '0;
      r_dcnt      <= '0;
      r_wcnt      <= '0;
      r_gcnt      <= '0;
      r_rcnt      <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      r_state     <= w_state_nxt;
      r_en        <= w_en_nxt;
      r_delay     <= w_delay_nxt;
      r_width     <= w_width_nxt;
      r_gap       <= w_gap_nxt;
      r_repeat    <= w_repeat_nxt;
      r_mode      <= w_mode_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_trig_prev <= w_trig;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // Highest set mode bit among 7,3,2,1,0 selects the combine function.
  always_comb begin
    clk_out = clk_in;
    if (r_en) begin
      casez (r_mode)
        8'b1???????: clk_out = r_en;
        8'b0???1???: clk_out = ~(clk_in & r_en);
        8'b0???01??: clk_out = clk_in ^ r_en;
        8'b0???001?: clk_out = clk_in | r_en;
        8'b0???0001: clk_out = clk_in & r_en;
        default:     clk_out = clk_in;
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_seq.sv
// Self-checking bench for glitch_seq: directed vector table, hand-written corner
// sequences, and randomized traffic against a timeline-based reference model.
module tb_glitch_seq;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clk_in, arm, abort, trigger;
  logic [15:0] delay;
  logic [7:0]  width, gap, mode;
  logic [3:0]  repeats;
  logic        clk_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  glitch_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_in  (clk_in),
    .arm     (arm),
    .abort   (abort),
    .trigger (trigger),
    .delay   (delay),
    .width   (width),
    .gap     (gap),
    .repeats (repeats),
    .mode    (mode),
    .clk_out (clk_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_clk(input logic [7:0] m, input logic en, input logic ci);
    if (!en)  return ci;
    if (m[7]) return en;
    if (m[3]) return ~(ci & en);
    if (m[2]) return ci ^ en;
    if (m[1]) return ci | en;
    if (m[0]) return ci & en;
    return ci;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int r, input logic [7:0] m);
    delay = 16'(d); width = 8'(w); gap = 8'(g); repeats = 4'(r); mode = m;
  endtask

  typedef struct {
    int         d, w, g, r;
    logic [7:0] m;
    int         first, len, cnt, period, done_at;
  } vec_t;

  vec_t vecs[4];

  initial begin
    clk_in = 1'b0;
    set_cfg(0, 0, 0, 0, 8'h00);
    do_reset();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_en", dut.r_en, 1'b0);

    // first/len/period/done_at are offsets from the trigger edge-detect cycle (no sync).
    vecs[0] = '{d:5, w:2, g:0, r:0, m:8'h01, first:6, len:3, cnt:1, period:100, done_at:9};
    vecs[1] = '{d:3, w:0, g:3, r:2, m:8'h02, first:4, len:1, cnt:3, period:5,   done_at:15};
    vecs[2] = '{d:0, w:0, g:0, r:0, m:8'h88, first:1, len:1, cnt:1, period:100, done_at:2};
    vecs[3] = '{d:2, w:1, g:1, r:1, m:8'h04, first:3, len:2, cnt:2, period:4,   done_at:9};

    for (int v = 0; v < 4; v++) begin
      do_reset();
      set_cfg(vecs[v].d, vecs[v].w, vecs[v].g, vecs[v].r, vecs[v].m);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      set_cfg(255, 255, 255, 15, 8'h00);  // later port changes must be ignored
      trigger = 1'b1;
      tick();
      for (int k = 0; k <= vecs[v].done_at + SYNC + 2; k++) begin
        int   o;
        logic exp_en;
        if (k > 0) tick();
        o = k - vecs[v].first - SYNC;
        exp_en = (o >= 0) && (o / vecs[v].period < vecs[v].cnt) && (o % vecs[v].period < vecs[v].len);
        clk_in = k[0];
        #1;
        check($sformatf("vec%0d_en_k%0d", v, k), dut.r_en, exp_en);
        check($sformatf("vec%0d_done_k%0d", v, k), done, (k == vecs[v].done_at + SYNC));
        check($sformatf("vec%0d_busy_k%0d", v, k), busy, (k <= vecs[v].done_at + SYNC));
        check($sformatf("vec%0d_clk_k%0d", v, k), clk_out, ref_clk(vecs[v].m, exp_en, clk_in));
      end
      trigger = 1'b0;
    end

    // Abort during GAP of a repeat=3 sequence: glitch at 2, gap spans 3..6.
    do_reset();
    set_cfg(1, 0, 3, 3, 8'h01);
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick();
    for (int k = 1; k <= 4 + SYNC; k++) tick();
    check("abort_pre_busy", busy, 1'b1);
    check("abort_pre_en", dut.r_en, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_en", dut.r_en, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_no_done", done, 1'b0);
      check("abort_stay_idle", busy, 1'b0);
    end
    trigger = 1'b0;

    // Reset mid-GLITCH wins over abort and arm; clk_out follows clk_in afterwards.
    do_reset();
    set_cfg(0, 3, 0, 0, 8'h88);
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick();
    for (int k = 1; k <= 2 + SYNC; k++) tick();
    clk_in = 1'b0; #1;
    check("rst_pre_en", dut.r_en, 1'b1);
    check("rst_pre_clk", clk_out, 1'b1);
    rst_n = 1'b0; abort = 1'b1; arm = 1'b1;
    tick();
    check("rst_en", dut.r_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    clk_in = 1'b0; #1; check("rst_clk0", clk_out, 1'b0);
    clk_in = 1'b1; #1; check("rst_clk1", clk_out, 1'b1);
    rst_n = 1'b1; abort = 1'b0; arm = 1'b0; trigger = 1'b0;
    tick();
    check("rst_after_busy", busy, 1'b0);

    // Trigger already high at arm time must not fire until a low-then-high edge.
    do_reset();
    trigger = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    set_cfg(0, 0, 0, 0, 8'h01);
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("held_trig_busy", busy, 1'b1);
      check("held_trig_en", dut.r_en, 1'b0);
    end
    trigger = 1'b0; tick();
    trigger = 1'b1; tick();
    for (int k = 1; k <= 1 + SYNC; k++) begin
      tick();
      check($sformatf("edge_fire_en_k%0d", k), dut.r_en, (k == 1 + SYNC));
    end
    trigger = 1'b0;

    // Randomized traffic against a timeline model.
    begin : rnd
      bit         m_armed, m_active;
      int         n, t0, md, mw, mg, mr, dn, k;
      logic [7:0] mm;
      logic       hist[3];
      logic       te, tp, exp_en, exp_done, exp_busy;

      do_reset();
      m_armed = 0; m_active = 0; n = 0; t0 = 0;
      md = 0; mw = 0; mg = 0; mr = 0; mm = 8'h00;
      hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;

      for (int c = 0; c < 4000; c++) begin
        rst_n = ($urandom_range(199) != 0);
        abort = ($urandom_range(59) == 0);
        arm   = ($urandom_range(7) == 0);
        if ($urandom_range(5) == 0) trigger = ~trigger;
        set_cfg($urandom_range(6), $urandom_range(3), $urandom_range(3), $urandom_range(3), 8'($urandom));
        tick();
        n++;

        if (SYNC != 0) begin te = hist[1]; tp = hist[2]; end
        else           begin te = trigger; tp = hist[0]; end

        dn = md + 1 + (mr + 1) * (mw + 1) + mr * (mg + 1);
        if (!rst_n) begin
          m_armed = 0; m_active = 0;
          md = 0; mw = 0; mg = 0; mr = 0; mm = 8'h00;
          hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
        end else begin
          if (abort) begin
            m_armed = 0; m_active = 0;
          end else if (m_active) begin
            if (n - t0 == dn + 1) m_active = 0;
          end else if (m_armed) begin
            if (te && !tp) begin m_armed = 0; m_active = 1; t0 = n; end
          end else if (arm) begin
            m_armed = 1;
            md = int'(delay); mw = int'(width); mg = int'(gap); mr = int'(repeats); mm = mode;
          end
          hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = trigger;
        end

        dn = md + 1 + (mr + 1) * (mw + 1) + mr * (mg + 1);
        k  = n - t0;
        exp_busy = m_armed || m_active;
        exp_done = m_active && (k == dn);
        exp_en   = m_active && (k >= md + 1) && (k < dn) && ((k - md - 1) % (mw + mg + 2) < mw + 1);

        check("rnd_busy", busy, exp_busy);
        check("rnd_done", done, exp_done);
        check("rnd_en", dut.r_en, exp_en);
        clk_in = 1'b0; #1; check("rnd_clk0", clk_out, ref_clk(mm, exp_en, 1'b0));
        clk_in = 1'b1; #1; check("rnd_clk1", clk_out, ref_clk(mm, exp_en, 1'b1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_seq.md
GLITCH_SEQ -- requirements
Module: glitch_seq

Interface
REQ-001 SHALL have parameter DELAY_W, default 16: width of the trigger-to-glitch delay count.
REQ-002 SHALL have parameter WIDTH_W, default 8: width of the glitch pulse-width and gap counts.
REQ-003 SHALL have parameter REP_W, default 4: width of the repeat count.
REQ-004 SHALL have port clk  input  1: system clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous to clk, active-low.
REQ-006 SHALL have port clk_in  input  1: target clock to be glitched.
REQ-007 SHALL have port arm  input  1: one-cycle request to latch the configuration and wait for the trigger.
REQ-008 SHALL have port abort  input  1: forces a return to IDLE.
REQ-009 SHALL have port trigger  input  1: external trigger, level; only its rising edge is used.
REQ-010 SHALL have port delay  input  DELAY_W: cycles from trigger edge to first glitch.
REQ-011 SHALL have port width  input  WIDTH_W: glitch length minus one, in clk cycles.
REQ-012 SHALL have port gap  input  WIDTH_W: spacing between glitches minus one, in clk cycles.
REQ-013 SHALL have port repeat  input  REP_W: number of additional glitches after the first.
REQ-014 SHALL have port mode  input  8: glitch combine mode.
REQ-015 SHALL have port clk_out  output  1: glitched clock.
REQ-016 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-017 SHALL have port done  output  1: one-cycle pulse when a sequence completes.

Function
REQ-018 SHALL implement the states IDLE, ARMED, DELAY, GLITCH, GAP and DONE, with state encoding left to the implementation.
REQ-019 SHALL, in IDLE with arm=1, latch delay, width, gap, repeat and mode into shadow registers and go to ARMED; port changes after this do not affect the active sequence.
REQ-020 SHALL, in ARMED, go to DELAY on a detected trigger rising edge (sampled trigger=1, previous sample=0); a trigger held high at arm time does not fire.
REQ-021 SHALL count DELAY for delay cycles; delay=0 goes to GLITCH on the next cycle; GLITCH is first entered D+1 cycles after the edge-detect cycle.
REQ-022 SHALL hold internal enable en=1 for exactly width+1 cycles while in GLITCH, and en=0 in all other states.
REQ-023 SHALL, at the end of GLITCH, go to GAP if the remaining repeat count is nonzero (decrementing it), otherwise go to DONE.
REQ-024 SHALL stay in GAP for gap+1 cycles, then return to GLITCH.
REQ-025 SHALL assert done for one cycle in DONE, then go to IDLE.
REQ-026 SHALL, on abort=1 in any state, go to IDLE on the next edge with en=0 and without a done pulse; abort has priority over arm and trigger.
REQ-027 SHALL ignore arm outside IDLE.
REQ-028 SHALL generate clk_out combinationally from clk_in, the registered en and the latched mode: clk_out=clk_in when en=0.
REQ-029 SHALL, when en=1, apply the first matching rule in this priority order:
- mode[7]: clk_out=en
- mode[3]: clk_out=~(clk_in&en)
- mode[2]: clk_out=clk_in^en
- mode[1]: clk_out=clk_in|en
- mode[0]: clk_out=clk_in&en
- otherwise: clk_out=clk_in
REQ-030 SHALL implement all counters as unsigned at parameter width with no wrap; a sequence of repeat=R yields exactly R+1 glitches.

Reset
REQ-031 SHALL, with rst_n=0 at a clk edge, set state=IDLE, en=0, busy=0, done=0, all counters and shadow registers to 0, and the trigger history to 0.
REQ-032 SHALL make reset win over abort, arm and trigger, including mid-GLITCH, where en drops on the reset edge.

Configuration
REQ-033 SHALL, with GLITCH_SEQ_TRIG_SYNC_EN defined, pass trigger through a two-flop synchronizer before edge detection, adding 2 cycles to the trigger-to-GLITCH latency; without the macro, trigger is edge-detected directly.

Verification
REQ-034 SHALL cover: arm with delay=5, width=2, repeat=0, mode=0x01, trigger edge at cycle T -> en high at T+6..T+8, done at T+9 (no sync macro).
REQ-035 SHALL cover: repeat=2, width=0, gap=3 -> three 1-cycle glitches spaced 4 cycles apart, one done pulse.
REQ-036 SHALL cover: delay=0, width=0 -> single 1-cycle glitch at T+1; mode=0x88 -> clk_out=1 during the glitch.
REQ-037 SHALL cover: abort asserted during GAP of repeat=3 -> IDLE next cycle, en=0, no done, busy=0.
REQ-038 SHALL cover: rst_n=0 during GLITCH -> clk_out follows clk_in from the next edge, state=IDLE; trigger high at arm -> no fire until a low-then-high edge.
REQ-039 SHALL cover: with GLITCH_SEQ_TRIG_SYNC_EN defined, the scenario of REQ-034 -> en high at T+8..T+10.
